packet_chk: RTL
===============

# packet_chk

Receive-side traffic checker for the raw 10G link. It consumes the user-side packet stream delivered by the 10G link core on `usclk`, checks each packet's framing, header, sequence number, length and payload against the shared test-packet format, and keeps saturating statistics. It is the counterpart of the `packet_gen` transmit generator. Together they form the loopback/BER test path, and the counters are exposed for readout over APB/UART.

## Interface
Parameters:
- `DATA_W`, default 64: stream data width. Only 64 is supported.
- `CNT_W`, default 32: width of each statistics counter.

Ports:
- `sys_clk` in 1: link user clock (`usclk`). This is the only clock.
- `sys_rst` in 1: synchronous, active-high reset. It is driven as `~fpga_rst_n | ~syn_align`.
- `rx_data` in 64: stream data. Byte 0 is `[7:0]`.
- `rx_data_en` in 1: beat valid.
- `rx_data_sop` in 1: first beat of a packet. Qualified by `rx_data_en`.
- `rx_data_eop` in 1: last beat of a packet. Qualified by `rx_data_en`.
- `rx_data_byte_vaild` in 3: number of valid bytes on the eop beat; 0 means 8. Ignored on non-eop beats.
- `stat_clr` in 1: pulse that clears all counters and `o_locked`.
- `o_locked` out 1: set by the first good packet after reset or clear.
- `o_good_pkt_cnt` out CNT_W: count of good packets.
- `o_bad_pkt_cnt` out CNT_W: count of packets with any error.
- `o_seq_err_cnt` out CNT_W: count of sequence errors.
- `o_frame_err_cnt` out CNT_W: count of framing errors.
- `o_err_pulse` out 1: one-cycle pulse for each bad packet or framing event.

## Operation
Packet format:
- Header beat (the sop beat):
  - bytes 0–3: 32-bit sequence number, little-endian.
  - bytes 4–5: total packet length in bytes, including the header.
  - bytes 6–7: magic `16'hA55A`.
- Payload: the byte at packet offset k (k ≥ 8) is `k[7:0]`.
- Valid lengths are 9..65535.

State machine:
- `IDLE`:
  - sop beat: check the header, set the byte offset to 8, go to `BODY`. A sop+eop beat is a one-beat packet, which always fails the length check.
  - `rx_data_en` without sop: framing error, beat ignored, stay in `IDLE`.
- `BODY`:
  - each beat compares its valid bytes against the expected pattern and adds them to the offset.
  - eop beat: close the packet, go to `IDLE`.
  - sop beat: framing error. The open packet is counted bad and the new packet starts on the same beat (header checked, stay in `BODY`).

Per-packet error flags (sticky until the packet closes):
- `hdr`: magic mismatch.
- `len`: header length ≠ final byte count. The offset saturates at 65535.
- `data`: any payload byte mismatch.
- `seq`: received seq ≠ expected seq. This check applies only when `o_locked`=1.

Sequence tracking:
- Expected seq is loaded with received seq + 1 (mod 2^32) at every packet close, good or bad, so a gap is counted once and then the checker resyncs.
- Before lock, the seq check is skipped.

Packet close:
- If no flag is set: `o_good_pkt_cnt`++ and `o_locked` is set.
- Otherwise: `o_bad_pkt_cnt`++ and `o_err_pulse` fires.
- `o_seq_err_cnt` increments on close if the `seq` flag is set.
- `o_frame_err_cnt` increments on each framing event. An ignored stray beat also pulses `o_err_pulse`.

Counters saturate at all-ones and never wrap.

## Timing
- Reset and `stat_clr`:
  - Reset puts the FSM in `IDLE`, sets all counters and `o_locked` to 0, `o_err_pulse` to 0, and expected seq to 0.
  - `stat_clr` clears the counters and `o_locked` only. The FSM keeps running.
- Input stage: all inputs are registered once. Byte compare happens in that stage. The flag reduction and counter update happen in the next stage.
- Latency: counters, `o_locked` and `o_err_pulse` reflect a packet 2 cycles after its eop beat is sampled. A framing event is reflected 2 cycles after its beat.
- Back-to-back traffic:
  - eop followed immediately by sop is legal and full-rate, with no idle cycle.
  - `rx_data_en` may deassert mid-packet. Gaps are ignored.
- Simultaneous events:
  - `stat_clr` and a counter increment in the same cycle: the clear wins and the increment is lost.
  - Two increments of the same counter never land in the same cycle.
- Reset mid-packet discards the open packet and counts nothing.

## Structure
- Package `pkt_fmt_pkg`, shared with `packet_gen`:
  - `PKT_MAGIC = 16'hA55A`
  - header field offsets
  - `PKT_HDR_BYTES = 8`
  - `PKT_MIN_LEN = 9`
  - a `pkt_hdr_t` packed struct: seq, len, magic
  - FSM enum `chk_state_e`
- Sub-module `packet_chk_cmp`: purely combinational compare. Given a 16-bit offset, 64-bit data and a byte-valid count, it returns one mismatch bit. It is instantiated once; the top level holds the FSM and counters.

## Test plan
- Reset, then 100 well-formed packets (len 64, seq 0..99, back-to-back): good=100, bad=0, seq=0, frame=0, locked=1.
- Seq jump: seq 0,1,2,5,6: good=4, bad=1, seq=1. The packet with seq 6 passes.
- Corrupt payload byte offset 20 of packet 3 (of 5): bad=1, good=4, one `o_err_pulse` 2 cycles after that eop.
- Header len 100, actual 96 bytes (eop byte_vaild=0 on beat 12): bad=1 with the `len` flag. Byte_vaild=4 on beat 13 (len 100): good.
- sop mid-packet, then a stray en beat in `IDLE`: frame=2, bad=1. The second packet checks good.
- Counters preloaded near 2^CNT_W−1 via CNT_W=4 (16 packets): good saturates at 15. Then `stat_clr` in the same cycle as an increment leaves good=0 and locked=0.

Source files
------------

// File: rtl/pkt_fmt_pkg.sv
// pkt_fmt_pkg: test-packet format shared by packet_gen and packet_chk
package pkt_fmt_pkg;
  localparam logic [15:0] PKT_MAGIC = 16'hA55A;
  localparam int PKT_SEQ_OFF = 0;
  localparam int PKT_LEN_OFF = 4;
  localparam int PKT_MAGIC_OFF = 6;
  localparam int PKT_HDR_BYTES = 8;
  localparam int PKT_MIN_LEN = 9;
  typedef struct packed {
    logic [15:0] magic;
    logic [15:0] len;
    logic [31:0] seq;
  } pkt_hdr_t;
  typedef struct packed {
    logic hdr;
    logic len;
    logic data;
    logic seq;
  } pkt_err_t;
  typedef enum logic {IDLE, BODY} chk_state_e;
  function automatic pkt_hdr_t hdr_of(input logic [63:0] d);
    return '{magic: d[PKT_MAGIC_OFF*8 +: 16], len: d[PKT_LEN_OFF*8 +: 16], seq: d[PKT_SEQ_OFF*8 +: 32]};
  endfunction
endpackage

// File: rtl/packet_chk_if.sv
// packet_chk_if: user-side receive stream from the 10G link core
interface packet_chk_if #(parameter int DATA_W = 64);
  logic [DATA_W-1:0] rx_data;
  logic rx_data_en;
  logic rx_data_sop;
  logic rx_data_eop;
  logic [2:0] rx_data_byte_vaild;
  modport master(output rx_data, rx_data_en, rx_data_sop, rx_data_eop, rx_data_byte_vaild);
  modport slave(input rx_data, rx_data_en, rx_data_sop, rx_data_eop, rx_data_byte_vaild);
endinterface

// File: rtl/packet_chk_cmp.sv
// packet_chk_cmp: flags any valid byte that differs from the offset-derived payload pattern
module packet_chk_cmp (
  input  logic [15:0] off,
  input  logic [63:0] data,
  input  logic [3:0]  nb,
  output logic        mis
);
  // byte i of the beat must equal the low byte of its packet offset
  always_comb begin
    mis = 1'b0;
    for (int i = 0; i < 8; i++) mis |= (4'(i) < nb) && (data[i*8 +: 8] != 8'(off + 16'(i)));
  end
endmodule

// File: rtl/packet_chk.sv
// packet_chk: receive-side test-packet checker with saturating statistics
module packet_chk
  import pkt_fmt_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  packet_chk_if.slave      rx,
  input  logic             stat_clr,
  output logic             o_locked,
  output logic [CNT_W-1:0] o_good_pkt_cnt,
  output logic [CNT_W-1:0] o_bad_pkt_cnt,
  output logic [CNT_W-1:0] o_seq_err_cnt,
  output logic [CNT_W-1:0] o_frame_err_cnt,
  output logic             o_err_pulse
);
  logic [DATA_W-1:0] data_q;
  logic en_q, sop_q, eop_q, clr_q;
  logic [2:0] bv_q;
  chk_state_e state_q, state_d;
  logic [15:0] off_q, off_d, len_q, len_d, c_len, c_off;
  logic [31:0] seq_q, seq_d, exp_q, exp_d, c_seq;
  pkt_err_t err_q, err_d, c_err;
  logic good_ev_q, good_ev_d, bad_ev_q, bad_ev_d, seq_ev_q, seq_ev_d, frame_ev_q, frame_ev_d;
  logic locked_q, locked_d, pulse_q, pulse_d, close, mis;
  logic [CNT_W-1:0] good_q, good_d, bad_q, bad_d, seqc_q, seqc_d, frame_q, frame_d;
  logic [3:0] nb;
  logic [16:0] sum;
  pkt_hdr_t hdr;

  packet_chk_cmp u_cmp (.off(off_q), .data(data_q[63:0]), .nb(nb), .mis(mis));

  // stage 2 updates statistics from the events; stage 1 runs the FSM on the registered beat
  always_comb begin
    hdr = hdr_of(data_q[63:0]);
    nb = (eop_q && bv_q != 3'd0) ? {1'b0, bv_q} : 4'd8;
    sum = {1'b0, off_q} + 17'(nb);
    locked_d = clr_q ? 1'b0 : locked_q | good_ev_q;
    good_d = clr_q ? '0 : good_q + CNT_W'(good_ev_q & ~&good_q);
    bad_d = clr_q ? '0 : bad_q + CNT_W'(bad_ev_q & ~&bad_q);
    seqc_d = clr_q ? '0 : seqc_q + CNT_W'(seq_ev_q & ~&seqc_q);
    frame_d = clr_q ? '0 : frame_q + CNT_W'(frame_ev_q & ~&frame_q);
    pulse_d = bad_ev_q | frame_ev_q;
    state_d = state_q;
    off_d = off_q;
    len_d = len_q;
    seq_d = seq_q;
    err_d = err_q;
    exp_d = exp_q;
    frame_ev_d = 1'b0;
    close = 1'b0;
    c_seq = seq_q;
    c_len = len_q;
    c_off = off_q;
    c_err = err_q;
    if (en_q && sop_q) begin
      frame_ev_d = state_q == BODY;
      close = state_q == BODY || eop_q;
      state_d = eop_q ? IDLE : BODY;
      off_d = 16'(PKT_HDR_BYTES);
      len_d = hdr.len;
      seq_d = hdr.seq;
      err_d = '{hdr: hdr.magic != PKT_MAGIC, default: 1'b0};
      c_seq = eop_q ? hdr.seq : seq_q;
      c_len = eop_q ? hdr.len : len_q;
      c_off = eop_q ? 16'(PKT_HDR_BYTES) : off_q;
      c_err = eop_q ? err_d : err_q;
    end else if (en_q && state_q == IDLE) begin
      frame_ev_d = 1'b1;
    end else if (en_q) begin
      off_d = sum[16] ? 16'hFFFF : sum[15:0];
      err_d.data = err_q.data | mis;
      close = eop_q;
      state_d = eop_q ? IDLE : BODY;
      c_off = off_d;
      c_err = err_d;
    end
    c_err.len = c_err.len | (c_len != c_off) | (c_len < 16'(PKT_MIN_LEN));
    c_err.seq = locked_d && c_seq != exp_q;
    good_ev_d = close && !(|c_err) && !frame_ev_d;
    bad_ev_d = close && !good_ev_d;
    seq_ev_d = close && c_err.seq;
    exp_d = close ? c_seq + 32'd1 : exp_q;
  end

  // input stage, FSM stage and statistics stage registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      data_q <= '0;
      en_q <= 1'b0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
      bv_q <= '0;
      clr_q <= 1'b0;
      state_q <= IDLE;
      off_q <= '0;
      len_q <= '0;
      seq_q <= '0;
      err_q <= '0;
      exp_q <= '0;
      good_ev_q <= 1'b0;
      bad_ev_q <= 1'b0;
      seq_ev_q <= 1'b0;
      frame_ev_q <= 1'b0;
      locked_q <= 1'b0;
      pulse_q <= 1'b0;
      good_q <= '0;
      bad_q <= '0;
      seqc_q <= '0;
      frame_q <= '0;
    end else begin
      data_q <= rx.rx_data;
      en_q <= rx.rx_data_en;
      sop_q <= rx.rx_data_sop;
      eop_q <= rx.rx_data_eop;
      bv_q <= rx.rx_data_byte_vaild;
      clr_q <= stat_clr;
      state_q <= state_d;
      off_q <= off_d;
      len_q <= len_d;
      seq_q <= seq_d;
      err_q <= err_d;
      exp_q <= exp_d;
      good_ev_q <= good_ev_d;
      bad_ev_q <= bad_ev_d;
      seq_ev_q <= seq_ev_d;
      frame_ev_q <= frame_ev_d;
      locked_q <= locked_d;
      pulse_q <= pulse_d;
      good_q <= good_d;
      bad_q <= bad_d;
      seqc_q <= seqc_d;
      frame_q <= frame_d;
    end
  end

  assign o_locked = locked_q;
  assign o_good_pkt_cnt = good_q;
  assign o_bad_pkt_cnt = bad_q;
  assign o_seq_err_cnt = seqc_q;
  assign o_frame_err_cnt = frame_q;
  assign o_err_pulse = pulse_q;
endmodule
